// File: rtl/bht_update_scheduler_if.sv
// Lookup, resolved-branch update and table-port signals of the BHT update scheduler.
// The scheduler connects through the slave modport; the pipeline/table side uses master.
interface bht_update_scheduler_if #(
  parameter int IDX_W      = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             lk_req;
  logic [IDX_W-1:0] lk_addr;
  logic             lk_gnt;
  logic             lk_valid;
  logic             lk_pred;

  logic             upd_valid;
  logic [IDX_W-1:0] upd_addr;
  logic             upd_taken;
  logic             upd_ready;
  logic [CNT_W-1:0] upd_pending;

  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;

  modport slave (
    input  lk_req, lk_addr, upd_valid, upd_addr, upd_taken, tbl_rdata,
    output lk_gnt, lk_valid, lk_pred, upd_ready, upd_pending,
           tbl_en, tbl_we, tbl_addr, tbl_wdata
  );

  modport master (
    output lk_req, lk_addr, upd_valid, upd_addr, upd_taken, tbl_rdata,
    input  lk_gnt, lk_valid, lk_pred, upd_ready, upd_pending,
           tbl_en, tbl_we, tbl_addr, tbl_wdata
  );
endinterface

// File: rtl/bht_update_scheduler.sv
// Arbitrates the single BHT port between fetch lookups and queued resolved-branch
// updates. Updates are applied as an atomic read-modify-write pair; a starvation
// down-counter forces the pending update once lookups have held the port long enough.
//
// state  | meaning
// IDLE   | port free: serve lookup, or issue update read of the queue head
// UPD_RD | read data for head returns; write saturated counter and pop
module bht_update_scheduler #(
  parameter int IDX_W      = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input logic                   clk,
  input logic                   arst,
  bht_update_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_LOAD = STV_W'(STARVE_MAX);

  typedef enum logic {IDLE, UPD_RD} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        q_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   q_taken;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [STV_W-1:0]        starve_left;
  logic                    lk_valid_q;
  logic                    empty, full, push, pop, rd_issue, force_upd;

  // 2-bit saturating counter step; never wraps.
  function automatic logic [1:0] sat(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign push      = bus.upd_valid & ~full;
  // starve_left counts the lookup grants still allowed ahead of a queued update
  assign force_upd = ~empty & (starve_left == '0);

  assign bus.upd_ready   = ~full;
  assign bus.upd_pending = count;
  assign bus.lk_valid    = lk_valid_q;
  assign bus.lk_pred     = lk_valid_q & bus.tbl_rdata[1];

  // Port ownership and next-state decision.
  always_comb begin
    state_nxt     = state;
    bus.lk_gnt    = 1'b0;
    bus.tbl_en    = 1'b0;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = '0;
    pop           = 1'b0;
    rd_issue      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.lk_req && !force_upd) begin
          bus.lk_gnt   = 1'b1;
          bus.tbl_en   = 1'b1;
          bus.tbl_addr = bus.lk_addr;
        end else if (!empty) begin
          bus.tbl_en   = 1'b1;
          bus.tbl_addr = q_addr[rd_ptr];
          rd_issue     = 1'b1;
          state_nxt    = UPD_RD;
        end
      end
      UPD_RD: begin
        bus.tbl_en    = 1'b1;
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = q_addr[rd_ptr];
        bus.tbl_wdata = sat(bus.tbl_rdata, q_taken[rd_ptr]);
        pop           = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Queue pointers and occupancy; a pop never frees a slot for a same-cycle push.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue payload storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= bus.upd_addr;
      q_taken[wr_ptr] <= bus.upd_taken;
    end
  end

  // Starvation budget: reload when nothing waits or the update read goes out.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      starve_left <= STV_LOAD;
    end else if (empty || rd_issue) begin
      starve_left <= STV_LOAD;
    end else if (bus.lk_gnt && starve_left != '0) begin
      starve_left <= starve_left - 1'b1;
    end
  end

  // Lookup data returns one cycle after the grant.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) lk_valid_q <= 1'b0;
    else      lk_valid_q <= bus.lk_gnt;
  end
endmodule

// File: tb/tb_bht_update_scheduler.sv
// Bench for bht_update_scheduler: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_bht_update_scheduler;
  localparam int IDX_W      = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 3;
  localparam int N_ENT      = 1 << IDX_W;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  bht_update_scheduler_if #(.IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  bht_update_scheduler #(.IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] bht     [N_ENT];
  logic [1:0] ref_tbl [N_ENT];

  typedef struct {
    logic [IDX_W-1:0] addr;
    logic             taken;
  } upd_t;

  upd_t mq[$];
  int   m_starve;
  bit   m_busy, m_lv, m_lp;

  logic             e_gnt, e_en, e_we, e_rd, e_ready, e_valid, e_pred;
  logic [IDX_W-1:0] e_addr;
  logic [1:0]       e_wdata;
  int               e_pend;

  typedef struct {
    logic lr; logic [IDX_W-1:0] la; logic uv; logic [IDX_W-1:0] ua; logic ut;
    logic gnt, vld, prd, en, we; logic [IDX_W-1:0] addr; logic [1:0] wd; logic rdy; int pend;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lr, input logic [IDX_W-1:0] la, input logic uv,
                       input logic [IDX_W-1:0] ua, input logic ut);
    bus.lk_req    = lr;
    bus.lk_addr   = la;
    bus.upd_valid = uv;
    bus.upd_addr  = ua;
    bus.upd_taken = ut;
  endtask

  // Advance one cycle, acting as the BHT storage with 1-cycle read latency.
  task automatic tick();
    logic en, we;
    logic [IDX_W-1:0] a;
    logic [1:0] wd;
    en = bus.tbl_en; we = bus.tbl_we; a = bus.tbl_addr; wd = bus.tbl_wdata;
    @(posedge clk);
    if (en && !we) bus.tbl_rdata = bht[a];
    if (en && we)  bht[a] = wd;
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_busy   = 0;
    m_lv     = 0;
    m_lp     = 0;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    arst = 1'b1;
    #1;
    model_reset();
    chk("rst.tbl_en", 32'(bus.tbl_en), 32'(0));
    chk("rst.upd_ready", 32'(bus.upd_ready), 32'(1));
    chk("rst.upd_pending", 32'(bus.upd_pending), 32'(0));
    chk("rst.lk_valid", 32'(bus.lk_valid), 32'(0));
    repeat (2) @(negedge clk);
    arst = 1'b0;
  endtask

  function automatic logic [1:0] ref_sat(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  // Expected outputs for the current cycle from the arbitration rules.
  task automatic model_eval();
    bit force_u;
    e_gnt = 0; e_en = 0; e_we = 0; e_rd = 0; e_addr = '0; e_wdata = '0;
    if (m_busy) begin
      e_en    = 1;
      e_we    = 1;
      e_addr  = mq[0].addr;
      e_wdata = ref_sat(ref_tbl[mq[0].addr], mq[0].taken);
    end else begin
      force_u = (mq.size() != 0) && (m_starve == STARVE_MAX);
      if (bus.lk_req && !force_u) begin
        e_gnt  = 1;
        e_en   = 1;
        e_addr = bus.lk_addr;
      end else if (mq.size() != 0) begin
        e_en   = 1;
        e_addr = mq[0].addr;
        e_rd   = 1;
      end
    end
    e_ready = (mq.size() < FIFO_DEPTH);
    e_pend  = mq.size();
    e_valid = m_lv;
    e_pred  = m_lv & m_lp;
  endtask

  task automatic model_commit();
    int   sz;
    upd_t u;
    sz   = mq.size();
    m_lv = e_gnt;
    m_lp = e_gnt ? ref_tbl[bus.lk_addr][1] : 1'b0;
    if (sz == 0 || e_rd)                      m_starve = 0;
    else if (e_gnt && m_starve < STARVE_MAX) m_starve++;
    if (m_busy) begin
      ref_tbl[mq[0].addr] = e_wdata;
      void'(mq.pop_front());
      m_busy = 0;
    end else if (e_rd) begin
      m_busy = 1;
    end
    if (bus.upd_valid && sz < FIFO_DEPTH) begin
      u.addr  = bus.upd_addr;
      u.taken = bus.upd_taken;
      mq.push_back(u);
    end
  endtask

  task automatic model_check();
    chk("rnd.lk_gnt", 32'(bus.lk_gnt), 32'(e_gnt));
    chk("rnd.lk_valid", 32'(bus.lk_valid), 32'(e_valid));
    chk("rnd.lk_pred", 32'(bus.lk_pred), 32'(e_pred));
    chk("rnd.tbl_en", 32'(bus.tbl_en), 32'(e_en));
    chk("rnd.tbl_we", 32'(bus.tbl_we), 32'(e_we));
    chk("rnd.tbl_addr", 32'(bus.tbl_addr), 32'(e_addr));
    chk("rnd.tbl_wdata", 32'(bus.tbl_wdata), 32'(e_wdata));
    chk("rnd.upd_ready", 32'(bus.upd_ready), 32'(e_ready));
    chk("rnd.upd_pending", 32'(bus.upd_pending), 32'(e_pend));
  endtask

  task automatic add(input int lr, input int la, input int uv, input int ua, input int ut,
                     input int gnt, input int vld, input int prd, input int en, input int we,
                     input int addr, input int wd, input int rdy, input int pend);
    vec_t v;
    v.lr = 1'(lr); v.la = IDX_W'(la); v.uv = 1'(uv); v.ua = IDX_W'(ua); v.ut = 1'(ut);
    v.gnt = 1'(gnt); v.vld = 1'(vld); v.prd = 1'(prd); v.en = 1'(en); v.we = 1'(we);
    v.addr = IDX_W'(addr); v.wd = 2'(wd); v.rdy = 1'(rdy); v.pend = pend;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDX_W-1:0] wq[$];
    int budget;

    arst = 1'b1;
    bus.tbl_rdata = 2'b00;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);

    //  lr la uv ua ut | gnt vld prd en we addr wd rdy pend
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 4, 0, 0, 0,   1, 0, 0, 1, 0, 4, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 7, 0, 0, 0,   1, 0, 0, 1, 0, 7, 0, 1, 0);
    add(1, 4, 0, 0, 0,   1, 1, 1, 1, 0, 4, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 3, 1,   0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 3, 0, 1, 1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 3, 2, 1, 1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 7, 1,   0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 7, 0, 1, 1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 7, 3, 1, 1);
    add(0, 0, 1, 9, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 9, 0, 1, 1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 9, 0, 1, 1);
    add(1, 1, 1, 10, 0,  1, 0, 0, 1, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0,   1, 1, 0, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 0, 0,   1, 1, 0, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 0, 0,   1, 1, 0, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 0, 0,   0, 1, 0, 1, 0, 10, 0, 1, 1);
    add(1, 1, 0, 0, 0,   0, 0, 0, 1, 1, 10, 1, 1, 1);
    add(1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 1, 0, 1, 0);
    add(1, 10, 0, 0, 0,  1, 1, 0, 1, 0, 10, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 3, 0, 0, 0,   1, 0, 0, 1, 0, 3, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Directed vectors
    for (int i = 0; i < N_ENT; i++) bht[i] = 2'b00;
    bht[4] = 2'b01; bht[7] = 2'b11; bht[3] = 2'b01; bht[10] = 2'b10;
    do_reset();
    foreach (vt[i]) begin
      drive(vt[i].lr, vt[i].la, vt[i].uv, vt[i].ua, vt[i].ut);
      #1;
      chk($sformatf("vec%0d.lk_gnt", i), 32'(bus.lk_gnt), 32'(vt[i].gnt));
      chk($sformatf("vec%0d.lk_valid", i), 32'(bus.lk_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d.lk_pred", i), 32'(bus.lk_pred), 32'(vt[i].prd));
      chk($sformatf("vec%0d.tbl_en", i), 32'(bus.tbl_en), 32'(vt[i].en));
      chk($sformatf("vec%0d.tbl_we", i), 32'(bus.tbl_we), 32'(vt[i].we));
      chk($sformatf("vec%0d.tbl_addr", i), 32'(bus.tbl_addr), 32'(vt[i].addr));
      chk($sformatf("vec%0d.tbl_wdata", i), 32'(bus.tbl_wdata), 32'(vt[i].wd));
      chk($sformatf("vec%0d.upd_ready", i), 32'(bus.upd_ready), 32'(vt[i].rdy));
      chk($sformatf("vec%0d.upd_pending", i), 32'(bus.upd_pending), 32'(vt[i].pend));
      tick();
    end

    // Queue fill under continuous lookups: fifth update must be dropped
    for (int i = 0; i < N_ENT; i++) bht[i] = 2'b00;
    do_reset();
    drive(1'b1, '0, 1'b1, IDX_W'(5), 1'b1);  #1; tick();
    drive(1'b1, '0, 1'b1, IDX_W'(6), 1'b1);  #1; tick();
    drive(1'b1, '0, 1'b1, IDX_W'(8), 1'b1);  #1; tick();
    drive(1'b1, '0, 1'b1, IDX_W'(11), 1'b1); #1;
    chk("full.c3_gnt", 32'(bus.lk_gnt), 32'(1));
    tick();
    drive(1'b1, '0, 1'b1, IDX_W'(12), 1'b1); #1;
    chk("full.c4_ready", 32'(bus.upd_ready), 32'(0));
    chk("full.c4_pending", 32'(bus.upd_pending), 32'(4));
    chk("full.c4_gnt", 32'(bus.lk_gnt), 32'(0));
    chk("full.c4_rd_addr", 32'(bus.tbl_addr), 32'(5));
    tick();
    #1;
    chk("full.c5_we", 32'(bus.tbl_we), 32'(1));
    chk("full.c5_gnt", 32'(bus.lk_gnt), 32'(0));
    chk("full.c5_ready", 32'(bus.upd_ready), 32'(0));
    chk("full.c5_pending", 32'(bus.upd_pending), 32'(4));
    wq.push_back(bus.tbl_addr);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0); #1;
    chk("full.c6_pending", 32'(bus.upd_pending), 32'(3));
    budget = 0;
    while (wq.size() < 4 && budget < 30) begin
      if (bus.tbl_en && bus.tbl_we) wq.push_back(bus.tbl_addr);
      tick();
      #1;
      budget++;
    end
    chk("full.drain_count", 32'(wq.size()), 32'(4));
    if (wq.size() == 4) begin
      chk("full.order0", 32'(wq[0]), 32'(5));
      chk("full.order1", 32'(wq[1]), 32'(6));
      chk("full.order2", 32'(wq[2]), 32'(8));
      chk("full.order3", 32'(wq[3]), 32'(11));
    end
    repeat (4) tick();
    chk("full.end_pending", 32'(bus.upd_pending), 32'(0));
    chk("full.dropped_entry", 32'(bht[12]), 32'(0));
    chk("full.entry5", 32'(bht[5]), 32'(1));

    // Reset while the write half of an update is due
    bht[13] = 2'b10;
    do_reset();
    drive(1'b0, '0, 1'b1, IDX_W'(13), 1'b1); #1; tick();
    drive(1'b0, '0, 1'b1, IDX_W'(14), 1'b0); #1;
    chk("rstmid.rd_issue", 32'(bus.tbl_en), 32'(1));
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0); #1;
    chk("rstmid.pre_we", 32'(bus.tbl_we), 32'(1));
    arst = 1'b1;
    #1;
    chk("rstmid.we", 32'(bus.tbl_we), 32'(0));
    chk("rstmid.pending", 32'(bus.upd_pending), 32'(0));
    chk("rstmid.ready", 32'(bus.upd_ready), 32'(1));
    tick();
    chk("rstmid.entry_kept", 32'(bht[13]), 32'(2));
    arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rstmid.no_port", 32'(bus.tbl_en), 32'(0));
      tick();
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < N_ENT; i++) begin
      bht[i]     = 2'($urandom_range(0, 3));
      ref_tbl[i] = bht[i];
    end
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom_range(0, 9) < 7), IDX_W'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      #1;
      model_eval();
      model_check();
      model_commit();
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      #1;
      model_eval();
      model_check();
      model_commit();
      tick();
    end
    for (int i = 0; i < N_ENT; i++)
      chk($sformatf("rnd.table[%0d]", i), 32'(bht[i]), 32'(ref_tbl[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
